// File: rtl/cpu54_pkg.sv
// Shared definitions for the EX/MEM boundary: default widths and the
// packed layout of one buffered EX result.
package cpu54_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;

  // Number of slots in the EX/MEM elastic buffer.
  localparam logic [1:0] DEPTH = 2'd2;

  // One EX result travelling to MEM, at the default widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] r;
    logic [RD_W_DEF-1:0]   rd;
    logic                  wen;
  } entry_t;

endpackage

// File: rtl/ex_mem_skid.sv
// Two-entry in-order elastic buffer between the EX and MEM stages.
// The head slot always drives the MEM-side outputs; the tail slot holds
// the younger entry and shifts into the head on a pop. in_ready depends
// only on the registered count, so out_ready never reaches in_ready
// combinationally.
module ex_mem_skid
  import cpu54_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic [1:0]        count
);

  // Same layout as entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [RD_W-1:0]   rd;
    logic              wen;
  } slot_t;

  slot_t      head_q;
  slot_t      tail_q;
  logic [1:0] count_q;

  slot_t      new_slot;
  logic       push;
  logic       pop;

  // Register $0 is hardwired, so an entry targeting it never writes back.
  function automatic slot_t make_slot(input logic [DATA_W-1:0] r,
                                      input logic [RD_W-1:0]   rd,
                                      input logic              wen);
    slot_t s;
    s.r   = r;
    s.rd  = rd;
    s.wen = wen & (rd != '0);
    return s;
  endfunction

  assign in_ready  = (count_q != DEPTH);
  assign out_valid = (count_q != 2'd0);
  assign count     = count_q;

  // flush blocks both handshakes so nothing is accepted or reported as consumed.
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = out_valid & out_ready & ~flush;
  assign new_slot = make_slot(in_r, in_rd, in_wen);

  // MEM-side fields read zero whenever no entry is presented.
  assign out_r   = out_valid ? head_q.r   : '0;
  assign out_rd  = out_valid ? head_q.rd  : '0;
  assign out_wen = out_valid ? head_q.wen : 1'b0;

  // Occupancy and slot update; reset outranks flush, which outranks push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          // Fill the first free slot; the head stays the oldest entry.
          if (count_q == 2'd0) begin
            head_q <= new_slot;
          end else begin
            tail_q <= new_slot;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // Younger entry (or an empty slot) moves up to the head.
          head_q  <= tail_q;
          tail_q  <= '0;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new entry replaces the head.
          head_q <= new_slot;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: a table of per-cycle vectors with the
// expected post-edge outputs, followed by a long-stall and drain sequence.
module tb_ex_mem_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_r;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [1:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_mem_skid #(.DATA_W(32), .RD_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_rd    (out_rd),
    .out_wen   (out_wen),
    .count     (count)
  );

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        iv;
    logic [31:0] r;
    logic [4:0]  rd;
    logic        wen;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_r;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic [1:0]  e_cnt;
    logic        e_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rn, input logic fl, input logic iv,
                     input logic [31:0] r, input logic [4:0] rd, input logic wen,
                     input logic ordy, input logic e_ov, input logic [31:0] e_r,
                     input logic [4:0] e_rd, input logic e_wen,
                     input logic [1:0] e_cnt, input logic e_ir);
    vec_t v;
    v.rst_n = rn; v.flush = fl; v.iv = iv; v.r = r; v.rd = rd; v.wen = wen;
    v.ordy = ordy; v.e_ov = e_ov; v.e_r = e_r; v.e_rd = e_rd; v.e_wen = e_wen;
    v.e_cnt = e_cnt; v.e_ir = e_ir;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ov, input logic [31:0] e_r,
                           input logic [4:0] e_rd, input logic e_wen,
                           input logic [1:0] e_cnt, input logic e_ir);
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
    check({tag, " out_r"},     out_r,              e_r);
    check({tag, " out_rd"},    {27'd0, out_rd},    {27'd0, e_rd});
    check({tag, " out_wen"},   {31'd0, out_wen},   {31'd0, e_wen});
    check({tag, " count"},     {30'd0, count},     {30'd0, e_cnt});
    check({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
  endtask

  task automatic drive(input logic rn, input logic fl, input logic iv,
                       input logic [31:0] r, input logic [4:0] rd, input logic wen,
                       input logic ordy);
    rst_n = rn; flush = fl; in_valid = iv; in_r = r; in_rd = rd; in_wen = wen;
    out_ready = ordy;
  endtask

  initial begin
    logic [31:0] popped[$];
    int          budget;

    //  rn fl iv r             rd  wen or | ov r             rd  wen cnt ir
    add(0, 0, 0, 32'h0,        0,  0,  0,   0, 32'h0,        0,  0,  0,  1); // reset
    add(1, 0, 1, 32'h0000FFFF, 3,  1,  1,   1, 32'h0000FFFF, 3,  1,  1,  1); // push
    add(1, 0, 0, 32'h0,        0,  0,  1,   0, 32'h0,        0,  0,  0,  1); // pop -> empty
    add(1, 0, 1, 32'hAAAA0000, 4,  1,  0,   1, 32'hAAAA0000, 4,  1,  1,  1);
    add(1, 0, 1, 32'h5555FFFF, 5,  1,  0,   1, 32'hAAAA0000, 4,  1,  2,  0); // full
    add(1, 0, 1, 32'h00000077, 7,  1,  0,   1, 32'hAAAA0000, 4,  1,  2,  0); // push refused
    add(1, 0, 0, 32'h0,        0,  0,  1,   1, 32'h5555FFFF, 5,  1,  1,  1); // in order
    add(1, 0, 0, 32'h0,        0,  0,  1,   0, 32'h0,        0,  0,  0,  1);
    add(1, 0, 1, 32'h00000001, 1,  1,  0,   1, 32'h00000001, 1,  1,  1,  1);
    add(1, 0, 1, 32'h00000002, 2,  0,  1,   1, 32'h00000002, 2,  0,  1,  1); // push+pop
    add(1, 0, 1, 32'hFFFFFFFF, 0,  1,  0,   1, 32'h00000002, 2,  0,  2,  0); // rd=0 entry
    add(1, 0, 0, 32'h0,        0,  0,  1,   1, 32'hFFFFFFFF, 0,  0,  1,  1); // wen forced 0
    add(1, 0, 1, 32'h00000033, 6,  1,  0,   1, 32'hFFFFFFFF, 0,  0,  2,  0);
    add(1, 1, 1, 32'h00000044, 9,  1,  1,   0, 32'h0,        0,  0,  0,  1); // flush
    add(1, 0, 0, 32'h0,        0,  0,  1,   0, 32'h0,        0,  0,  0,  1); // nothing leaks
    add(1, 1, 1, 32'h00000055, 9,  1,  0,   0, 32'h0,        0,  0,  0,  1); // flush drops push
    add(1, 0, 1, 32'h00000010, 7,  1,  0,   1, 32'h00000010, 7,  1,  1,  1);
    add(1, 0, 1, 32'h00000020, 8,  1,  0,   1, 32'h00000010, 7,  1,  2,  0);
    add(0, 1, 1, 32'h00000099, 9,  1,  1,   0, 32'h0,        0,  0,  0,  1); // reset mid-run
    add(1, 0, 0, 32'h0,        0,  0,  1,   0, 32'h0,        0,  0,  0,  1);

    drive(0, 0, 0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].iv, vecs[i].r, vecs[i].rd,
            vecs[i].wen, vecs[i].ordy);
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].e_ov, vecs[i].e_r, vecs[i].e_rd,
                vecs[i].e_wen, vecs[i].e_cnt, vecs[i].e_ir);
    end

    // Long stall: two entries must hold for many cycles with out_ready low.
    drive(1, 0, 1, 32'hCAFE0001, 5'd9, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1, 0, 1, 32'hBEEF0002, 5'd10, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1, 0, 0, 32'h0, 5'd0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check_all($sformatf("stall%0d", c), 1'b1, 32'hCAFE0001, 5'd9, 1'b1, 2'd2, 1'b0);
    end

    // Drain: record each head as it is accepted, within a cycle budget.
    out_ready = 1'b1;
    budget = 10;
    while (popped.size() < 2 && budget > 0) begin
      if (out_valid) popped.push_back(out_r);
      @(posedge clk); #1;
      budget--;
    end
    check("drain count", popped.size(), 32'd2);
    if (popped.size() == 2) begin
      check("drain first",  popped[0], 32'hCAFE0001);
      check("drain second", popped[1], 32'hBEEF0002);
    end
    check_all("drained", 1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
